qos_vc_scheduler: RTL and testbench

// - Weighted round-robin scheduler sharing one output FIFO between 4 virtual-channel input FIFOs of the QoS module.
// - Honours the per-FIFO pause_stb/continue_stb strobes produced by the QoS control FSM.
// - Sits between the VC input FIFOs (first-word-fall-through, head data valid whenever !empty) and the shared egress FIFO.

---
 rtl/qos_vc_scheduler_if.sv | 24 ++
 rtl/qos_vc_scheduler.sv | 114 +++++++++++
 tb/tb_qos_vc_scheduler.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qos_vc_scheduler_if.sv
// Ingress FIFO heads and egress FIFO write port of the QoS VC scheduler.
// The master side is the FIFO side (it supplies heads and afull) and the slave side is the scheduler.
interface qos_vc_scheduler_if #(
   parameter int unsigned NUM_VC = 4,
   parameter int unsigned DATA_W = 6
);
   logic [NUM_VC-1:0]        vc_empty;
   logic [NUM_VC*DATA_W-1:0] vc_data;
   logic [NUM_VC-1:0]        vc_pop;
   logic                     out_afull;
   logic                     out_push;
   logic [DATA_W-1:0]        out_data;
   logic [1:0]               out_vc;

   modport master (
      output vc_empty, vc_data, out_afull,
      input  vc_pop, out_push, out_data, out_vc
   );

   modport slave (
      input  vc_empty, vc_data, out_afull,
      output vc_pop, out_push, out_data, out_vc
   );
endinterface

// File: rtl/qos_vc_scheduler.sv
// Weighted round-robin scheduler: several first-word-fall-through VC FIFOs feed one egress FIFO,
// honouring per-VC pause/continue strobes.
module qos_vc_scheduler #(
   parameter int unsigned NUM_VC   = 4,
   parameter int unsigned DATA_W   = 6,
   parameter int unsigned WEIGHT_W = 3
) (
   input  logic                         CLK,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [NUM_VC*WEIGHT_W-1:0]   cfg_weight,
   input  logic [NUM_VC-1:0]            pause_stb,
   input  logic [NUM_VC-1:0]            continue_stb,
   qos_vc_scheduler_if.slave            bus,
   output logic [NUM_VC-1:0]            grant,
   output logic [NUM_VC-1:0]            paused
);
   localparam int unsigned IDX_W = 2;

   typedef enum logic [1:0] {StIdle, StArb, StServe} state_e;

   state_e              state;
   logic [WEIGHT_W-1:0] credit;
   logic [IDX_W-1:0]    rr_ptr;
   logic [IDX_W-1:0]    cur_vc;
   logic                push_q;
   logic [DATA_W-1:0]   data_q;
   logic [IDX_W-1:0]    vc_q;

   logic [NUM_VC-1:0]   eligible;
   logic                found;
   logic [IDX_W-1:0]    pick;
   logic [WEIGHT_W-1:0] pick_w;
   logic                cur_elig;
   logic                pop_ok;
   logic [DATA_W-1:0]   cur_data;

   assign eligible = ~bus.vc_empty & ~paused & {NUM_VC{enable}};
   assign cur_elig = eligible[cur_vc];
   assign cur_data = bus.vc_data[cur_vc*DATA_W +: DATA_W];
   assign pop_ok   = (state == StServe) && cur_elig && !bus.out_afull;
   assign pick_w   = cfg_weight[pick*WEIGHT_W +: WEIGHT_W];

   // First eligible VC scanning upward from rr_ptr, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr;
      for (int k = 0; k < NUM_VC; k++) begin
         logic [IDX_W-1:0] idx;
         idx = IDX_W'((32'(rr_ptr) + 32'(k)) % NUM_VC);
         if (!found && eligible[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      bus.vc_pop = '0;
      if (pop_ok) bus.vc_pop[cur_vc] = 1'b1;
   end

   assign bus.out_push = push_q;
   assign bus.out_data = data_q;
   assign bus.out_vc   = vc_q;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state  <= StIdle;
         paused <= '0;
         grant  <= '0;
         credit <= '0;
         rr_ptr <= '0;
         cur_vc <= '0;
         push_q <= 1'b0;
         data_q <= '0;
         vc_q   <= '0;
      end else begin
         // Pause wins over a simultaneous continue.
         paused <= (paused & ~continue_stb) | pause_stb;
         push_q <= pop_ok;
         if (pop_ok) begin
            data_q <= cur_data;
            vc_q   <= cur_vc;
         end
         unique case (state)
            StIdle: begin
               if (|eligible) state <= StArb;
            end
            StArb: begin
               if (found) begin
                  grant  <= NUM_VC'(1) << pick;
                  cur_vc <= pick;
                  credit <= (pick_w == '0) ? WEIGHT_W'(1) : pick_w;
                  state  <= StServe;
               end else begin
                  state <= StIdle;
               end
            end
            StServe: begin
               // out_afull alone holds grant and credit; losing eligibility ends the turn.
               if (!cur_elig || (pop_ok && credit == WEIGHT_W'(1))) begin
                  rr_ptr <= cur_vc + IDX_W'(1);
                  grant  <= '0;
                  state  <= StArb;
               end else if (pop_ok) begin
                  credit <= credit - WEIGHT_W'(1);
               end
            end
            default: state <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_qos_vc_scheduler.sv
// Directed bench for qos_vc_scheduler: behavioural VC FIFOs, logged pushes and grants,
// hand-computed expectations.
module tb_qos_vc_scheduler;
   logic        CLK = 1'b0;
   logic        reset;
   logic        enable;
   logic [11:0] cfg_weight;
   logic [3:0]  pause_stb;
   logic [3:0]  continue_stb;
   logic [3:0]  grant;
   logic [3:0]  paused;

   qos_vc_scheduler_if #(.NUM_VC(4), .DATA_W(6)) bus ();

   qos_vc_scheduler #(.NUM_VC(4), .DATA_W(6), .WEIGHT_W(3)) dut (
      .CLK          (CLK),
      .reset        (reset),
      .enable       (enable),
      .cfg_weight   (cfg_weight),
      .pause_stb    (pause_stb),
      .continue_stb (continue_stb),
      .bus          (bus),
      .grant        (grant),
      .paused       (paused)
   );

   always #5 CLK = ~CLK;

   logic [5:0] mem [4][16];
   int         hd [4];
   int         lvl [4];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   logic [3:0] prev_grant = '0;
   logic [7:0] push_log [$];
   int         push_cyc [$];
   int         grant_log [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_cmp++;
      assert (obs === req) else begin
         n_bad++;
         $display("FAIL %s: observed %0h required %0h", tag, obs, req);
         $error("check %s", tag);
      end
   endtask

   task automatic drive_fifo();
      for (int i = 0; i < 4; i++) begin
         bus.vc_empty[i]        = (lvl[i] == 0);
         bus.vc_data[i*6 +: 6]  = mem[i][hd[i] & 15];
      end
   endtask

   task automatic load(input int l0, input int l1, input int l2, input int l3);
      for (int i = 0; i < 4; i++) begin
         hd[i] = 0;
         for (int k = 0; k < 16; k++) mem[i][k] = 6'(i * 16 + k);
      end
      lvl[0] = l0; lvl[1] = l1; lvl[2] = l2; lvl[3] = l3;
      drive_fifo();
   endtask

   function automatic int idx_of(input logic [3:0] oh);
      for (int i = 0; i < 4; i++) if (oh[i]) return i;
      return -1;
   endfunction

   // One clock: pops the FIFO model as the DUT did, then logs pushes and new grants.
   task automatic step();
      logic [3:0] pops;
      @(negedge CLK);
      pops = bus.vc_pop;
      @(posedge CLK);
      #1;
      pause_stb    = '0;
      continue_stb = '0;
      for (int i = 0; i < 4; i++) begin
         if (pops[i] === 1'b1 && lvl[i] > 0) begin
            hd[i]++;
            lvl[i]--;
         end
      end
      drive_fifo();
      cyc++;
      if (bus.out_push === 1'b1) begin
         push_log.push_back({bus.out_vc, bus.out_data});
         push_cyc.push_back(cyc);
      end
      if (grant != '0 && prev_grant == '0) grant_log.push_back(idx_of(grant));
      prev_grant = grant;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      push_log.delete();
      push_cyc.delete();
      grant_log.delete();
      prev_grant = '0;
   endtask

   task automatic run_pushes(input int n, input int limit, input string tag);
      int c = 0;
      while (push_log.size() < n && c < limit) begin
         step();
         c++;
      end
      check(tag, 32'(push_log.size()), 32'(n));
   endtask

   task automatic run_grants(input int n, input int limit, input string tag);
      int c = 0;
      while (grant_log.size() < n && c < limit) begin
         step();
         c++;
      end
      check(tag, 32'(grant_log.size()), 32'(n));
   endtask

   function automatic logic [7:0] word(input int v, input int w);
      logic [1:0] vv;
      vv = 2'(v);
      return {vv, 6'(v * 16 + w)};
   endfunction

   initial begin
      int cnt [4];
      int nxt [4];
      int j;
      int nvc2;

      reset = 1'b1;
      enable = 1'b1;
      cfg_weight = {3'd1, 3'd1, 3'd1, 3'd1};
      pause_stb = '0;
      continue_stb = '0;
      bus.out_afull = 1'b0;

      // Equal weights: grants 0,1,2,3,0... with one push every second cycle.
      load(16, 16, 16, 16);
      do_reset();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_paused", 32'(paused), 32'h0);
      check("rst_push", 32'(bus.out_push), 32'h0);
      check("rst_data", 32'(bus.out_data), 32'h0);
      check("rst_vc", 32'(bus.out_vc), 32'h0);
      check("rst_pop", 32'(bus.vc_pop), 32'h0);
      run_pushes(8, 40, "rr_push_count");
      for (int k = 0; k < 8; k++) begin
         if (k < push_log.size()) check($sformatf("rr_push%0d", k), 32'(push_log[k]),
                                        32'(word(k % 4, k / 4)));
         if (k >= 1 && k < push_cyc.size())
            check($sformatf("rr_gap%0d", k), 32'(push_cyc[k] - push_cyc[k-1]), 32'd2);
         if (k < grant_log.size()) check($sformatf("rr_grant%0d", k), 32'(grant_log[k]), 32'(k % 4));
      end

      // Weights 3,1,0,2: 0 counts as 1.
      cfg_weight = {3'd2, 3'd0, 3'd1, 3'd3};
      load(16, 16, 16, 16);
      do_reset();
      run_pushes(14, 60, "wrr_push_count");
      cnt[0] = 3; cnt[1] = 1; cnt[2] = 1; cnt[3] = 2;
      for (int v = 0; v < 4; v++) nxt[v] = 0;
      j = 0;
      for (int r = 0; r < 2; r++) begin
         for (int v = 0; v < 4; v++) begin
            for (int n = 0; n < cnt[v]; n++) begin
               if (j < push_log.size())
                  check($sformatf("wrr_push%0d", j), 32'(push_log[j]), 32'(word(v, nxt[v])));
               nxt[v]++;
               j++;
            end
         end
      end

      // Pause VC1 during the VC0 turn, then continue it, then pause+continue together.
      cfg_weight = {3'd1, 3'd1, 3'd1, 3'd1};
      load(16, 16, 16, 16);
      do_reset();
      run_grants(1, 10, "pause_first_grant");
      check("pause_at_vc0", 32'(grant), 32'h1);
      pause_stb = 4'b0010;
      step();
      check("pause_mask", 32'(paused), 32'h2);
      grant_log.delete();
      run_grants(3, 20, "pause_grant_count");
      for (int k = 0; k < 3; k++)
         if (k < grant_log.size())
            check($sformatf("pause_grant%0d", k), 32'(grant_log[k]), 32'((k + 2) % 4));
      continue_stb = 4'b0010;
      step();
      check("cont_mask", 32'(paused), 32'h0);
      grant_log.delete();
      run_grants(3, 20, "cont_grant_count");
      for (int k = 0; k < 3; k++)
         if (k < grant_log.size())
            check($sformatf("cont_grant%0d", k), 32'(grant_log[k]), 32'(k + 1));
      pause_stb = 4'b0010;
      continue_stb = 4'b0010;
      step();
      check("both_mask", 32'(paused), 32'h2);

      // out_afull for 5 cycles after the first pop of a weight-4 turn.
      cfg_weight = {3'd1, 3'd1, 3'd1, 3'd4};
      load(16, 16, 16, 16);
      do_reset();
      run_pushes(1, 10, "afull_first_push");
      bus.out_afull = 1'b1;
      #1;
      check("afull_pop_off", 32'(bus.vc_pop), 32'h0);
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("afull_nopush%0d", k), 32'(bus.out_push), 32'h0);
         check($sformatf("afull_grant%0d", k), 32'(grant), 32'h1);
      end
      bus.out_afull = 1'b0;
      #1;
      check("afull_resume_pop", 32'(bus.vc_pop), 32'h1);
      run_pushes(4, 10, "afull_push_count");
      for (int k = 0; k < 4; k++)
         if (k < push_log.size()) check($sformatf("afull_push%0d", k), 32'(push_log[k]), 32'(word(0, k)));
      if (push_cyc.size() >= 2) check("afull_gap", 32'(push_cyc[1] - push_cyc[0]), 32'd6);
      run_grants(2, 10, "afull_next_count");
      if (grant_log.size() >= 2) check("afull_next_grant", 32'(grant_log[1]), 32'd1);

      // VC2 runs dry with credit left; next turn goes to VC3, or VC0 if VC3 is empty.
      cfg_weight = {3'd1, 3'd4, 3'd1, 3'd1};
      load(16, 16, 2, 16);
      do_reset();
      run_grants(4, 30, "dry_grant_count");
      for (int k = 0; k < 4; k++)
         if (k < grant_log.size()) check($sformatf("dry_grant%0d", k), 32'(grant_log[k]), 32'(k));
      nvc2 = 0;
      foreach (push_log[k]) if (push_log[k][7:6] == 2'd2) nvc2++;
      check("dry_vc2_pushes", 32'(nvc2), 32'd2);
      load(16, 16, 2, 0);
      do_reset();
      run_grants(4, 30, "dry3_grant_count");
      if (grant_log.size() >= 4) check("dry3_wrap_grant", 32'(grant_log[3]), 32'd0);

      // Reset while SERVE has a push in flight.
      cfg_weight = {3'd1, 3'd1, 3'd1, 3'd3};
      load(16, 16, 16, 16);
      do_reset();
      pause_stb = 4'b1000;
      step();
      run_pushes(1, 10, "mid_first_push");
      check("mid_pre_push", 32'(bus.out_push), 32'h1);
      check("mid_pre_grant", 32'(grant), 32'h1);
      reset = 1'b1;
      step();
      check("mid_push", 32'(bus.out_push), 32'h0);
      check("mid_grant", 32'(grant), 32'h0);
      check("mid_paused", 32'(paused), 32'h0);
      check("mid_pop", 32'(bus.vc_pop), 32'h0);
      check("mid_data", 32'(bus.out_data), 32'h0);
      check("mid_vc", 32'(bus.out_vc), 32'h0);
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
